video_scanlines: RTL
====================

VIDEO_SCANLINES -- requirements
Module: video_scanlines

Interface
REQ-001 Parameter HALF_DEPTH, default 0, SHALL select colour width: DW=3 when 1, DW=7 when 0.
REQ-002 clk_vid  in  1  video clock; sole clock, all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ce_pix  in  1  pixel enable from scandoubler (ce_pix_out); pipeline advances only when 1.
REQ-005 scanlines  in  2  requested effect: 0 off, 1 = 25% dim, 2 = 50% dim, 3 = 75% dim.
REQ-006 hs_in, vs_in  in  1 each  scandoubled syncs, active-high.
REQ-007 hb_in, vb_in  in  1 each  scandoubled blanking, active-high.
REQ-008 r_in, g_in, b_in  in  DW+1 each  scandoubled colour.
REQ-009 hs_out, vs_out, hb_out, vb_out  out  1 each  syncs/blanks delayed to match colour.
REQ-010 r_out, g_out, b_out  out  DW+1 each  processed colour.

Function
REQ-011 Pipeline: two ce_pix-qualified register stages; every output SHALL lag its input by exactly 2 ce_pix pulses; no output changes on cycles where ce_pix=0.
REQ-012 Edge detection: hs_in and vs_in rising edges SHALL be detected in clk_vid domain against previous clk_vid sample, regardless of ce_pix.
REQ-013 Line parity flag odd: toggles on each hs_in rising edge; cleared to 0 on each vs_in rising edge.
REQ-014 Simultaneous hs_in and vs_in rising edges in same cycle: vs wins, odd=0.
REQ-015 Active mode register mode[1:0]: loaded from scanlines only on vs_in rising edge; mid-frame changes of scanlines SHALL have no effect until next vs_in rising edge.
REQ-016 Stage 1 SHALL capture colour, hs/vs/hb/vb, current odd and mode on ce_pix.
REQ-017 Stage 2 SHALL compute per channel c: mode 0 or captured odd=0 -> c; mode 1 -> (c>>1)+(c>>2); mode 2 -> c>>1; mode 3 -> c>>2.
REQ-018 Arithmetic SHALL be unsigned DW+1 bit; mode-1 sum cannot overflow, no saturation logic required.
REQ-019 Any pixel captured with hb or vb high SHALL output colour 0 on all channels, whatever mode/odd.
REQ-020 odd and mode SHALL be sampled with the pixel at stage 1, so an hs edge arriving while data is in stage 2 does not alter that pixel.
REQ-021 Even lines (odd=0) SHALL always pass colour unmodified (subject to REQ-019).

Reset
REQ-022 While reset=1: all outputs 0, odd=0, mode=0, both pipeline stages 0, edge-detect history 0.
REQ-023 Reset asserted mid-line/mid-frame SHALL clear immediately (asynchronously) without waiting for clk_vid or ce_pix.
REQ-024 After reset release, first vs_in rising edge SHALL load mode; until then effect is off (mode 0).
REQ-025 If hs_in or vs_in is already high at reset release, no edge SHALL be detected for it.

Verification
REQ-026 scanlines=2, one vs pulse, then 2 lines of r=g=b=8'hFF, hb/vb low -> line 0 out FF, line 1 out 7F, each 2 ce_pix after input.
REQ-027 scanlines=1, odd line, r_in=8'hC8 -> r_out=8'h96; scanlines=3, r_in=8'hC8 -> r_out=8'h32.
REQ-028 Change scanlines 0->3 mid-frame -> output unchanged until after next vs_in rise, then odd lines divided by 4.
REQ-029 hs_in and vs_in rise in same clk_vid -> following line treated as even (undimmed).
REQ-030 hb_in=1 with r_in=FF, scanlines=0 -> r_out=0 two ce_pix later; ce_pix held low 10 cycles -> all outputs frozen.
REQ-031 Assert reset during active odd line with mode 2 -> outputs 0 within same cycle; after release, undimmed output until new vs edge.

Source files
------------

// File: rtl/video_scanlines.sv
// Scanline dimmer for scandoubled video: darkens odd lines by a frame-latched amount
// through a two-stage ce_pix pipeline, keeping syncs/blanks aligned with colour.
module video_scanlines #(
    parameter int HALF_DEPTH = 0,
    localparam int DW = (HALF_DEPTH != 0) ? 3 : 7
) (
    input  logic        clk_vid,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic [1:0]  scanlines,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        hb_in,
    input  logic        vb_in,
    input  logic [DW:0] r_in,
    input  logic [DW:0] g_in,
    input  logic [DW:0] b_in,
    output logic        hs_out,
    output logic        vs_out,
    output logic        hb_out,
    output logic        vb_out,
    output logic [DW:0] r_out,
    output logic [DW:0] g_out,
    output logic [DW:0] b_out
);

    logic        hs_prev_reg;
    logic        vs_prev_reg;
    logic        armed_reg;
    logic        odd_reg;
    logic [1:0]  mode_reg;
    logic        hs_rise;
    logic        vs_rise;

    logic [DW:0] col_in [3];
    logic [DW:0] s1_col_reg [3];
    logic [DW:0] s2_col_reg [3];
    logic [3:0]  s1_sync_reg;
    logic [3:0]  s2_sync_reg;
    logic        s1_odd_reg;
    logic [1:0]  s1_mode_reg;
    logic        s1_blank;

    // armed_reg suppresses a false edge when a sync is already high at reset release
    assign hs_rise = armed_reg && hs_in && !hs_prev_reg;
    assign vs_rise = armed_reg && vs_in && !vs_prev_reg;

    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            hs_prev_reg <= 1'b0;
            vs_prev_reg <= 1'b0;
            armed_reg   <= 1'b0;
            odd_reg     <= 1'b0;
            mode_reg    <= 2'd0;
        end else begin
            hs_prev_reg <= hs_in;
            vs_prev_reg <= vs_in;
            armed_reg   <= 1'b1;
            if (vs_rise) begin
                odd_reg  <= 1'b0;
                mode_reg <= scanlines;
            end else if (hs_rise) begin
                odd_reg  <= ~odd_reg;
            end
        end
    end

    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            s1_sync_reg <= '0;
            s2_sync_reg <= '0;
            s1_odd_reg  <= 1'b0;
            s1_mode_reg <= 2'd0;
        end else if (ce_pix) begin
            s1_sync_reg <= {hs_in, vs_in, hb_in, vb_in};
            s2_sync_reg <= s1_sync_reg;
            s1_odd_reg  <= odd_reg;
            s1_mode_reg <= mode_reg;
        end
    end

    assign s1_blank = s1_sync_reg[1] | s1_sync_reg[0];
    assign col_in[0] = r_in;
    assign col_in[1] = g_in;
    assign col_in[2] = b_in;

    function automatic logic [DW:0] dim(input logic [DW:0] c, input logic [1:0] m,
                                        input logic o, input logic blank);
        logic [DW:0] res;
        res = c;
        if (blank) begin
            res = '0;
        end else if (o) begin
            case (m)
                2'd1:    res = (c >> 1) + (c >> 2);
                2'd2:    res = c >> 1;
                2'd3:    res = c >> 2;
                default: res = c;
            endcase
        end
        return res;
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            always_ff @(posedge clk_vid or posedge reset) begin
                if (reset) begin
                    s1_col_reg[gi] <= '0;
                    s2_col_reg[gi] <= '0;
                end else if (ce_pix) begin
                    s1_col_reg[gi] <= col_in[gi];
                    s2_col_reg[gi] <= dim(s1_col_reg[gi], s1_mode_reg, s1_odd_reg, s1_blank);
                end
            end
        end
    endgenerate

    assign {hs_out, vs_out, hb_out, vb_out} = s2_sync_reg;
    assign r_out = s2_col_reg[0];
    assign g_out = s2_col_reg[1];
    assign b_out = s2_col_reg[2];

endmodule
